// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FWFT round-robin drain scheduler.
//   sched_state_e : FSM encoding (IDLE / XFER)
//   port_idx_w()  : port-index width for a given port count (min 1 bit)
package fifo_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } sched_state_e;

  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req        : per-port request vector
//   last_grant : port served last; search starts at last_grant+1
//   grant      : first requesting port found, wrapping modulo NUM_PORTS
//   any_req    : at least one request present (grant valid only then)
module rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_WIDTH-1:0] last_grant,
  output logic [PORT_WIDTH-1:0] grant,
  output logic                  any_req
);

  logic [PORT_WIDTH:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after last_grant is the one left standing.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = {1'b0, last_grant} + (PORT_WIDTH+1)'(i);
      if (idx >= (PORT_WIDTH+1)'(NUM_PORTS))
        idx = idx - (PORT_WIDTH+1)'(NUM_PORTS);
      if (req[idx[PORT_WIDTH-1:0]])
        grant = idx[PORT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain scheduler over NUM_PORTS FWFT FIFOs.
//   fifo_dout_i/fifo_empty_i/fifo_rd_en_o : FWFT read side, port p at slice p
//   port_en_i   : per-port enable mask
//   burst_len_i : max words per grant (0 -> 1), sampled at grant
//   dout_o/port_o/valid_o/ready_i : registered valid/ready output stage
//   busy_o      : FSM in XFER
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 4,
  parameter int PORT_WIDTH  = port_idx_w(NUM_PORTS),
  parameter int BURST_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout_i,
  input  logic [NUM_PORTS-1:0]            fifo_empty_i,
  output logic [NUM_PORTS-1:0]            fifo_rd_en_o,
  input  logic [NUM_PORTS-1:0]            port_en_i,
  input  logic [BURST_WIDTH-1:0]          burst_len_i,
  output logic [DATA_WIDTH-1:0]           dout_o,
  output logic [PORT_WIDTH-1:0]           port_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            busy_o
);

  sched_state_e           state, state_nxt;
  logic [PORT_WIDTH-1:0]  last_grant, grant, arb_grant;
  logic [BURST_WIDTH-1:0] burst_cnt, burst_max;
  logic                   any_req, can_load, sel_ready, pop, burst_done, cnt_last;
  logic [DATA_WIDTH-1:0]  head [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_head
    assign head[p] = fifo_dout_i[p*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_WIDTH(PORT_WIDTH)) u_arb (
    .req        (~fifo_empty_i & port_en_i),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  assign can_load  = !valid_o || ready_i;
  assign sel_ready = !fifo_empty_i[grant] && port_en_i[grant];
  // Extra MSB so a full-scale burst_max compares without wrapping.
  assign cnt_last  = ({1'b0, burst_cnt} + 1'b1) == {1'b0, burst_max};
  assign busy_o    = (state == ST_XFER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    burst_done = 1'b0;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_XFER;
      ST_XFER: begin
        pop = can_load && sel_ready;
        // Empty/disabled only ends the burst once the output stage could
        // have taken a word, so a stalled word never loses its grant.
        if ((pop && cnt_last) || (can_load && !sel_ready)) begin
          burst_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en_o        = '0;
    fifo_rd_en_o[grant] = pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_WIDTH'(NUM_PORTS-1);
      grant      <= '0;
      burst_cnt  <= '0;
      burst_max  <= '0;
      valid_o    <= 1'b0;
      dout_o     <= '0;
      port_o     <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        grant     <= arb_grant;
        burst_max <= (burst_len_i == '0) ? BURST_WIDTH'(1) : burst_len_i;
        burst_cnt <= '0;
      end
      if (pop && burst_cnt != burst_max) burst_cnt <= burst_cnt + 1'b1;
      if (burst_done) last_grant <= grant;
      // Output stage: load on pop, otherwise drop valid once accepted.
      if (pop) begin
        dout_o  <= head[grant];
        port_o  <= grant;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
module tb_fifo_rr_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] fifo_dout;
  logic [3:0]   fifo_empty, fifo_rd_en, port_en;
  logic [3:0]   burst_len;
  logic [31:0]  dout;
  logic [1:0]   port;
  logic         valid, ready, busy;

  int n_chk = 0, n_err = 0;

  // FWFT FIFO model: port g holds wr_cnt[g] words, head word encodes port/index.
  int wr_cnt [4];
  int rd_ptr [4];
  int cyc, bad_pop;
  logic [31:0] xfer_d [$];
  logic [1:0]  xfer_p [$];
  int          pop_cyc [$];

  always #5 clk = ~clk;

  fifo_rr_scheduler dut (
    .clk(clk), .rst(rst), .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en), .port_en_i(port_en), .burst_len_i(burst_len),
    .dout_o(dout), .port_o(port), .valid_o(valid), .ready_i(ready), .busy_o(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign fifo_empty[g]          = rd_ptr[g] >= wr_cnt[g];
    assign fifo_dout[g*32 +: 32]  = 32'hA000_0000 | 32'(g << 8) | 32'(rd_ptr[g]);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 4; p++) rd_ptr[p] <= 0;
      cyc     <= 0;
      bad_pop <= 0;
      xfer_d.delete();
      xfer_p.delete();
      pop_cyc.delete();
    end else begin
      cyc <= cyc + 1;
      if (valid && ready) begin
        xfer_d.push_back(dout);
        xfer_p.push_back(port);
      end
      if ($countones(fifo_rd_en) > 1) bad_pop <= bad_pop + 1;
      for (int p = 0; p < 4; p++)
        if (fifo_rd_en[p]) begin
          rd_ptr[p] <= rd_ptr[p] + 1;
          if (fifo_empty[p]) bad_pop <= bad_pop + 1;
          pop_cyc.push_back(cyc);
        end
    end
  end

  function automatic logic [31:0] w(input int p, input int i);
    return 32'hA000_0000 | 32'(p << 8) | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_xfer(input int k, input int p, input int i);
    chk($sformatf("xfer%0d_data", k), (k < xfer_d.size()) ? xfer_d[k] : 32'hDEAD_DEAD, w(p, i));
    chk($sformatf("xfer%0d_port", k), (k < xfer_p.size()) ? 32'(xfer_p[k]) : 32'hDEAD_DEAD, 32'(p));
  endtask

  // Enter reset and load a new configuration; caller releases rst.
  task automatic apply(input logic [3:0] en, input logic [3:0] blen,
                       input int c0, input int c1, input int c2, input int c3);
    @(negedge clk);
    rst = 1'b0;
    port_en = en; burst_len = blen; ready = 1'b1;
    wr_cnt[0] = c0; wr_cnt[1] = c1; wr_cnt[2] = c2; wr_cnt[3] = c3;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    port_en = '0; burst_len = '0; ready = 1'b1;
    for (int p = 0; p < 4; p++) wr_cnt[p] = 0;

    // Reset state with every FIFO non-empty, then round robin, burst 2.
    apply(4'hF, 4'd2, 8, 8, 8, 8);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_dout",  dout, 0);
    chk("rst_port",  32'(port), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_first_rd_en", 32'(fifo_rd_en), 32'b0001);
    chk("rr_first_busy",  32'(busy), 1);
    chk("rr_first_valid", 32'(valid), 0);
    @(negedge clk);
    chk("rr_first_out_valid", 32'(valid), 1);
    chk("rr_first_out_dout",  dout, w(0, 0));
    repeat (60) @(negedge clk);
    chk("rr_count", 32'(xfer_d.size()), 32);
    for (int k = 0; k < 16; k++) chk_xfer(k, (k / 2) % 4, (k / 8) * 2 + k % 2);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_pop_cyc%0d", k), (k < pop_cyc.size()) ? 32'(pop_cyc[k]) : 32'hDEAD_DEAD,
          32'(1 + 3 * (k / 2) + k % 2));
    chk("rr_bad_pop", 32'(bad_pop), 0);
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_idle_valid", 32'(valid), 0);

    // Early drain: port 1 has 3 words under burst 5, port 2 follows.
    apply(4'hF, 4'd5, 0, 3, 2, 0);
    rst = 1'b1;
    repeat (16) @(negedge clk);
    chk("drain_count", 32'(xfer_d.size()), 5);
    for (int k = 0; k < 3; k++) chk_xfer(k, 1, k);
    chk_xfer(3, 2, 0);
    chk_xfer(4, 2, 1);
    chk("drain_bad_pop", 32'(bad_pop), 0);

    // Backpressure: ready low for 4 cycles mid-burst.
    apply(4'hF, 4'd8, 6, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_dout%0d", k),  dout, w(0, 1));
      chk($sformatf("bp_valid%0d", k), 32'(valid), 1);
      chk($sformatf("bp_rd_en%0d", k), 32'(fifo_rd_en), 0);
    end
    ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_count", 32'(xfer_d.size()), 6);
    for (int k = 0; k < 6; k++) chk_xfer(k, 0, k);
    chk("bp_bad_pop", 32'(bad_pop), 0);

    // burst_len 0 behaves as single-word bursts.
    apply(4'hF, 4'd0, 2, 2, 0, 0);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    chk("b0_count", 32'(xfer_d.size()), 4);
    chk_xfer(0, 0, 0); chk_xfer(1, 1, 0); chk_xfer(2, 0, 1); chk_xfer(3, 1, 1);
    chk("b0_pop_cyc1", (pop_cyc.size() > 1) ? 32'(pop_cyc[1]) : 32'hDEAD_DEAD, 3);

    // Mask 1010: only ports 1 and 3 served.
    apply(4'b1010, 4'd4, 2, 2, 2, 2);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    chk("mask_count", 32'(xfer_d.size()), 4);
    chk_xfer(0, 1, 0); chk_xfer(1, 1, 1); chk_xfer(2, 3, 0); chk_xfer(3, 3, 1);
    chk("mask_port0_untouched", 32'(rd_ptr[0]), 0);

    // Granted port disabled mid-burst: in-flight word still delivered.
    apply(4'hF, 4'd8, 8, 0, 1, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    port_en = 4'b1110;
    #1;
    chk("dis_rd_en", 32'(fifo_rd_en), 0);
    chk("dis_valid", 32'(valid), 1);
    chk("dis_dout",  dout, w(0, 0));
    repeat (10) @(negedge clk);
    chk("dis_count", 32'(xfer_d.size()), 2);
    chk_xfer(0, 0, 0);
    chk_xfer(1, 2, 0);
    chk("dis_port0_pops", 32'(rd_ptr[0]), 1);

    // Async reset in the middle of a port-1 burst.
    apply(4'hF, 4'd8, 1, 8, 0, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_pre_dout",  dout, w(1, 1));
    chk("ar_pre_valid", 32'(valid), 1);
    rst = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 0);
    chk("ar_busy",  32'(busy), 0);
    chk("ar_rd_en", 32'(fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_restart_rd_en", 32'(fifo_rd_en), 32'b0001);
    @(negedge clk);
    chk("ar_restart_dout", dout, w(0, 0));
    chk("ar_restart_port", 32'(port), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
